acc_window_ctrl: RTL

Sequencer for the bank of unsigned accumulators in the scalar unitary-ESPRIT correlation path. It turns a raw sample-valid stream into the per-sample valid and window-boundary ("acc_done") strobes shared by every accumulator in the bank. It qualifies which dump strobes carry a complete window and counts completed windows. Window length is programmable and range-checked against accumulator headroom so that accumulator overflow cannot occur.

---
 rtl/acc_ctrl_pkg.sv | 21 ++
 rtl/win_counter.sv | 38 +++
 rtl/acc_window_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
// rtl/acc_ctrl_pkg.sv - shared types, default widths and headroom helper for the accumulator window sequencer
package acc_ctrl_pkg;

    localparam int DIN_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF = 17;
    localparam int CNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_e;

    // Longest window whose sum of full-scale unsigned inputs still fits the accumulator.
    function automatic longint unsigned max_len(input int acc_w, input int din_w);
        return 64'd1 << (acc_w - din_w);
    endfunction

endpackage

// File: rtl/win_counter.sv
// rtl/win_counter.sv - modulo-len valid counter; boundary_o flags that the next valid opens a window
module win_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] len_i,
    output logic         boundary_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_inc >= len_i) ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign boundary_o = (cnt_q == '0);

endmodule

// File: rtl/acc_window_ctrl.sv
// rtl/acc_window_ctrl.sv - window sequencer producing valid/done/qualified-dump strobes for the accumulator bank
module acc_window_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_LEN = 1024,
    parameter int SYNC_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync_in,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 cfg_load,
    input  logic                 din_valid_in,
    output logic                 acc_valid_out,
    output logic                 acc_done_out,
    output logic                 dump_qual,
    output logic [CNT_WIDTH-1:0] win_cnt,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam longint unsigned MAX_LEN = max_len(ACC_WIDTH, DIN_WIDTH);

    if (DEFAULT_LEN < 1 || 64'(DEFAULT_LEN) > MAX_LEN) begin : g_bad_default_len
        $error("acc_window_ctrl: DEFAULT_LEN outside 1..MAX_LEN");
    end

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 cfg_err_q;
    logic                 first_q;
    logic [CNT_WIDTH-1:0] win_cnt_q;
    logic                 acc_valid_q, acc_done_q, dump_qual_q, busy_q;
    logic                 take, boundary, cnt_clr, cfg_ok, arm_entry;

    win_counter #(.W(LEN_WIDTH)) u_win_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .inc_i      (take),
        .len_i      (len_q),
        .boundary_o (boundary)
    );

    assign cfg_ok    = (cfg_len != '0) && (64'(cfg_len) <= MAX_LEN);
    assign arm_entry = (state_q == IDLE) && en;

    // take marks a valid that belongs to a window; only RUN and STOP feed the accumulators.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = ARM;
            end
            ARM: begin
                cnt_clr = 1'b1;
                if (!en)                          state_d = IDLE;
                else if (SYNC_EN == 0 || sync_in) state_d = RUN;
            end
            RUN: begin
                take = din_valid_in;
                if (!en) state_d = STOP;
            end
            STOP: begin
                take = din_valid_in;
                if (en)                    state_d = RUN;
                else if (take && boundary) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= LEN_WIDTH'(DEFAULT_LEN);
            cfg_err_q   <= 1'b0;
            first_q     <= 1'b1;
            win_cnt_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_done_q  <= 1'b0;
            dump_qual_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_valid_q <= take;
            acc_done_q  <= take & boundary;
            dump_qual_q <= take & boundary & ~first_q;
            busy_q      <= (state_q != IDLE);

            if (state_q == IDLE && cfg_load) begin
                cfg_err_q <= ~cfg_ok;
                if (cfg_ok) len_q <= cfg_len;
            end

            if (arm_entry)              first_q <= 1'b1;
            else if (take && boundary)  first_q <= 1'b0;

            // Count lands the cycle after the qualified dump strobe is seen downstream.
            if (arm_entry)        win_cnt_q <= '0;
            else if (dump_qual_q) win_cnt_q <= win_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign acc_valid_out = acc_valid_q;
    assign acc_done_out  = acc_done_q;
    assign dump_qual     = dump_qual_q;
    assign win_cnt       = win_cnt_q;
    assign busy          = busy_q;
    assign cfg_err       = cfg_err_q;

endmodule
